// File: rtl/if_stage_pkg.sv
// Shared types and defaults for the fetch stage and the main decoder.
package if_stage_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned ILEN     = 32;
    localparam int unsigned OPC_W    = 7;
    localparam int unsigned CNT_W    = 32;

    localparam logic [ILEN-1:0]     NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [XLEN_DEF-1:0] RESET_PC_DEF  = 32'h0000_0000;

    // RV32I major opcodes the decoder acts on
    typedef enum logic [OPC_W-1:0] {
        LOAD   = 7'b0000011,
        OP_IMM = 7'b0010011,
        STORE  = 7'b0100011,
        OP     = 7'b0110011,
        BRANCH = 7'b1100011,
        JAL    = 7'b1101111
    } opcode_t;

    function automatic opcode_t opcode_of(input logic [ILEN-1:0] instr);
        return opcode_t'(instr[OPC_W-1:0]);
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: loads the fetched word, holds on stall, bubbles on flush.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter int unsigned     XLEN      = XLEN_DEF,
    parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic [ILEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    output logic [ILEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            valid_o,
    output logic            load_c
);

    logic [ILEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic            valid_q, valid_d;

    // Flush beats stall; reset is applied in the register itself
    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        load_c     = 1'b0;
        if (flush) begin
            instr_d    = NOP_INSTR;
            pc_d       = '0;
            pc_plus4_d = '0;
            valid_d    = 1'b0;
        end else if (!stall) begin
            instr_d    = instr_i;
            pc_d       = pc_i;
            pc_plus4_d = pc_plus4_i;
            valid_d    = 1'b1;
            load_c     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, next-PC selection, misalign flag, fetch counter,
// and the IF/ID register feeding decode.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned     XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
    parameter logic [ILEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_f,
    input  logic              stall_d,
    input  logic              flush_d,
    input  logic              pc_src_e,
    input  logic [XLEN-1:0]   pc_target_e,
    output logic [XLEN-1:0]   imem_addr,
    input  logic [ILEN-1:0]   imem_rdata,
    output logic [XLEN-1:0]   pc_f,
    output logic [ILEN-1:0]   instr_d,
    output logic [OPC_W-1:0]  op_d,
    output logic [XLEN-1:0]   pc_d,
    output logic [XLEN-1:0]   pc_plus4_d,
    output logic              valid_d,
    output logic              misalign_f,
    output logic [CNT_W-1:0]  fetch_count
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0]  pc_f_q, pc_f_d;
    logic [XLEN-1:0]  pc_plus4_f_c;
    logic [XLEN-1:0]  redirect_pc_c;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
    logic             load_c;
    opcode_t          op_c;

    // Next PC: redirect wins over stall; redirect target is word-aligned
    always_comb begin
        pc_plus4_f_c  = pc_f_q + PC_STEP;
        redirect_pc_c = {pc_target_e[XLEN-1:2], 2'b00};
        pc_f_d        = pc_f_q;
        misalign_d    = 1'b0;
        fetch_count_d = fetch_count_q;
        if (pc_src_e) begin
            pc_f_d     = redirect_pc_c;
            misalign_d = (pc_target_e[1:0] != 2'b00);
        end else if (!stall_f) begin
            pc_f_d = pc_plus4_f_c;
        end
        if (load_c) begin
            fetch_count_d = fetch_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f_q        <= RESET_PC;
            misalign_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_f_q        <= pc_f_d;
            misalign_q    <= misalign_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    if_id_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall_d),
        .flush      (flush_d),
        .instr_i    (imem_rdata),
        .pc_i       (pc_f_q),
        .pc_plus4_i (pc_plus4_f_c),
        .instr_o    (instr_d),
        .pc_o       (pc_d),
        .pc_plus4_o (pc_plus4_d),
        .valid_o    (valid_d),
        .load_c     (load_c)
    );

    assign op_c        = opcode_of(instr_d);
    assign op_d        = op_c;
    assign pc_f        = pc_f_q;
    assign imem_addr   = pc_f_q;
    assign misalign_f  = misalign_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboarded bench for if_stage, with a second instance exercising PC wrap.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, stall_f, stall_d, flush_d, pc_src_e;
    logic [31:0] pc_target_e;

    logic [31:0] imem_addr, imem_rdata, pc_f, instr_d, pc_d, pc_plus4_d, fetch_count;
    logic [6:0]  op_d;
    logic        valid_d, misalign_f;

    logic [31:0] imem_addr_w, imem_rdata_w, pc_f_w, instr_d_w, pc_d_w, pc_plus4_d_w, fetch_count_w;
    logic [6:0]  op_d_w;
    logic        valid_d_w, misalign_f_w;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[24:0], 7'h33};
    endfunction

    assign imem_rdata   = mem_word(imem_addr);
    assign imem_rdata_w = mem_word(imem_addr_w);

    if_stage dut (
        .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .pc_f(pc_f), .instr_d(instr_d), .op_d(op_d), .pc_d(pc_d),
        .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .misalign_f(misalign_f),
        .fetch_count(fetch_count)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk(clk), .reset(reset), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .imem_addr(imem_addr_w),
        .imem_rdata(imem_rdata_w), .pc_f(pc_f_w), .instr_d(instr_d_w), .op_d(op_d_w),
        .pc_d(pc_d_w), .pc_plus4_d(pc_plus4_d_w), .valid_d(valid_d_w),
        .misalign_f(misalign_f_w), .fetch_count(fetch_count_w)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [6:0]  op;
        logic [31:0] pcd;
        logic [31:0] pc4;
        logic        valid;
        logic        mis;
        logic [31:0] cnt;
    } obs_t;

    obs_t        sb_q[$];
    logic [31:0] wq[$];
    int          checks   = 0;
    int          failures = 0;

    // Reference model state (RESET_PC = 0 instance)
    logic [31:0] m_pc = 0, m_instr = NOP, m_pcd = 0, m_pc4 = 0, m_cnt = 0;
    logic        m_valid = 0, m_mis = 0;

    function automatic obs_t observe();
        obs_t o;
        o.pc = pc_f; o.addr = imem_addr; o.instr = instr_d; o.op = op_d;
        o.pcd = pc_d; o.pc4 = pc_plus4_d; o.valid = valid_d; o.mis = misalign_f;
        o.cnt = fetch_count;
        return o;
    endfunction

    // Drive one cycle of stimulus and push the model's post-edge expectation
    task automatic drive(input logic r, input logic sf, input logic sd, input logic fl,
                         input logic ps, input logic [31:0] tgt);
        obs_t        e;
        logic [31:0] word;
        reset = r; stall_f = sf; stall_d = sd; flush_d = fl; pc_src_e = ps; pc_target_e = tgt;
        word = mem_word(m_pc);
        if (r) begin
            m_pc = 0; m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_valid = 0; m_mis = 0; m_cnt = 0;
        end else begin
            if (fl) begin
                m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_valid = 0;
            end else if (!sd) begin
                m_instr = word; m_pcd = m_pc; m_pc4 = m_pc + 32'd4; m_valid = 1; m_cnt = m_cnt + 1;
            end
            m_mis = ps && (tgt[1:0] != 2'b00);
            if (ps) m_pc = {tgt[31:2], 2'b00};
            else if (!sf) m_pc = m_pc + 32'd4;
        end
        e.pc = m_pc; e.addr = m_pc; e.instr = m_instr; e.op = m_instr[6:0];
        e.pcd = m_pcd; e.pc4 = m_pc4; e.valid = m_valid; e.mis = m_mis; e.cnt = m_cnt;
        sb_q.push_back(e);
    endtask

    task automatic test_reset();
        obs_t e, o;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 32'h0);
            @(posedge clk); #1;
            e = sb_q.pop_front(); o = observe(); checks++;
            if (o !== e) begin failures++; $display("FAIL reset[%0d] got=%h exp=%h", i, o, e); end
        end
        checks++;
        if ({pc_f, instr_d, op_d, pc_d, pc_plus4_d, valid_d, misalign_f, fetch_count} !==
            {32'h0, NOP, 7'b0010011, 64'h0, 2'b00, 32'h0}) begin
            failures++;
            $display("FAIL reset_values got pc=%h instr=%h op=%h valid=%b cnt=%0d", pc_f, instr_d, op_d, valid_d, fetch_count);
        end
    endtask

    task automatic test_sequential();
        obs_t e, o;
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 32'h0);
            @(posedge clk); #1;
            e = sb_q.pop_front(); o = observe(); checks++;
            if (o !== e) begin failures++; $display("FAIL seq[%0d] got=%h exp=%h", i, o, e); end
        end
        checks++;
        if ({pc_f, instr_d, valid_d, fetch_count} !== {32'h8, 32'h0000_0233, 1'b1, 32'd2}) begin
            failures++;
            $display("FAIL seq_const got pc=%h instr=%h valid=%b cnt=%0d exp pc=8 instr=233 valid=1 cnt=2", pc_f, instr_d, valid_d, fetch_count);
        end
    endtask

    task automatic test_stall();
        obs_t e, o;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) drive(0, 1, 1, 0, 0, 32'h0);
            else       drive(0, 0, 0, 0, 0, 32'h0);
            @(posedge clk); #1;
            e = sb_q.pop_front(); o = observe(); checks++;
            if (o !== e) begin failures++; $display("FAIL stall[%0d] got=%h exp=%h", i, o, e); end
            if (i == 1) begin
                checks++;
                if ({pc_f, instr_d, fetch_count} !== {32'h8, 32'h0000_0233, 32'd2}) begin
                    failures++;
                    $display("FAIL stall_hold got pc=%h instr=%h cnt=%0d exp pc=8 instr=233 cnt=2", pc_f, instr_d, fetch_count);
                end
            end
        end
        checks++;
        if ({instr_d, pc_d, fetch_count} !== {32'h0000_0433, 32'h8, 32'd3}) begin
            failures++;
            $display("FAIL stall_resume got instr=%h pcd=%h cnt=%0d exp instr=433 pcd=8 cnt=3", instr_d, pc_d, fetch_count);
        end
    endtask

    task automatic test_redirect_flush();
        obs_t e, o;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) drive(0, 0, 0, 1, 1, 32'h40);
            else        drive(0, 0, 0, 0, 0, 32'h0);
            @(posedge clk); #1;
            e = sb_q.pop_front(); o = observe(); checks++;
            if (o !== e) begin failures++; $display("FAIL redir_flush[%0d] got=%h exp=%h", i, o, e); end
            if (i == 0) begin
                checks++;
                if ({pc_f, instr_d, valid_d} !== {32'h40, NOP, 1'b0}) begin
                    failures++;
                    $display("FAIL redir_bubble got pc=%h instr=%h valid=%b exp pc=40 instr=13 valid=0", pc_f, instr_d, valid_d);
                end
            end
        end
        checks++;
        if (instr_d !== 32'h0000_2033) begin
            failures++; $display("FAIL redir_target_word got=%h exp=00002033", instr_d);
        end
    endtask

    task automatic test_redirect_stall();
        obs_t e, o;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) drive(0, 1, 1, 1, 1, 32'h80);
            else        drive(0, 0, 0, 0, 0, 32'h0);
            @(posedge clk); #1;
            e = sb_q.pop_front(); o = observe(); checks++;
            if (o !== e) begin failures++; $display("FAIL redir_stall[%0d] got=%h exp=%h", i, o, e); end
            if (i == 0) begin
                checks++;
                if ({pc_f, instr_d, valid_d} !== {32'h80, NOP, 1'b0}) begin
                    failures++;
                    $display("FAIL redir_over_stall got pc=%h instr=%h valid=%b exp pc=80 instr=13 valid=0", pc_f, instr_d, valid_d);
                end
            end
        end
    endtask

    task automatic test_misalign();
        obs_t e, o;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) drive(0, 0, 0, 0, 1, 32'h42);
            else        drive(0, 0, 0, 0, 0, 32'h0);
            @(posedge clk); #1;
            e = sb_q.pop_front(); o = observe(); checks++;
            if (o !== e) begin failures++; $display("FAIL misalign[%0d] got=%h exp=%h", i, o, e); end
            checks++;
            if ({pc_f, misalign_f} !== {(i == 0) ? 32'h40 : 32'h44, (i == 0) ? 1'b1 : 1'b0}) begin
                failures++;
                $display("FAIL misalign_flag[%0d] got pc=%h mis=%b", i, pc_f, misalign_f);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        obs_t e, o;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0:       drive(0, 1, 1, 0, 0, 32'h0);
                1:       drive(1, 1, 1, 1, 1, 32'h123);
                default: drive(0, 0, 0, 0, 0, 32'h0);
            endcase
            @(posedge clk); #1;
            e = sb_q.pop_front(); o = observe(); checks++;
            if (o !== e) begin failures++; $display("FAIL reset_stall[%0d] got=%h exp=%h", i, o, e); end
            if (i == 1) begin
                checks++;
                if ({pc_f, instr_d, op_d, pc_d, pc_plus4_d, valid_d, misalign_f, fetch_count} !==
                    {32'h0, NOP, 7'b0010011, 64'h0, 2'b00, 32'h0}) begin
                    failures++;
                    $display("FAIL reset_stall_values got pc=%h instr=%h valid=%b mis=%b cnt=%0d", pc_f, instr_d, valid_d, misalign_f, fetch_count);
                end
            end
        end
        checks++;
        if ({pc_f, instr_d, valid_d} !== {32'h4, 32'h0000_0033, 1'b1}) begin
            failures++;
            $display("FAIL first_post_reset got pc=%h instr=%h valid=%b exp pc=4 instr=33 valid=1", pc_f, instr_d, valid_d);
        end
    endtask

    task automatic test_back_to_back();
        obs_t        e, o;
        logic        r, sf, sd, fl, ps;
        logic [31:0] tgt;
        for (int i = 0; i < 60; i++) begin
            r   = ($urandom_range(0, 19) == 0);
            sf  = ($urandom_range(0, 3) == 0);
            sd  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 5) == 0);
            ps  = ($urandom_range(0, 5) == 0);
            tgt = $urandom();
            drive(r, sf, sd, fl, ps, tgt);
            @(posedge clk); #1;
            e = sb_q.pop_front(); o = observe(); checks++;
            if (o !== e) begin failures++; $display("FAIL rand[%0d] got=%h exp=%h", i, o, e); end
        end
    endtask

    task automatic test_wrap();
        obs_t        e, o;
        logic [31:0] wexp;
        for (int i = 0; i < 4; i++) begin
            drive((i == 0), 0, 0, 0, 0, 32'h0);
            case (i)
                0:       wq.push_back(32'hFFFF_FFF8);
                1:       wq.push_back(32'hFFFF_FFFC);
                2:       wq.push_back(32'h0000_0000);
                default: wq.push_back(32'h0000_0004);
            endcase
            @(posedge clk); #1;
            e = sb_q.pop_front(); o = observe(); checks++;
            if (o !== e) begin failures++; $display("FAIL wrap_main[%0d] got=%h exp=%h", i, o, e); end
            wexp = wq.pop_front(); checks++;
            if (pc_f_w !== wexp || imem_addr_w !== wexp) begin
                failures++; $display("FAIL wrap_pc[%0d] got=%h exp=%h", i, pc_f_w, wexp);
            end
            if (i == 2) begin
                checks++;
                if ({pc_d_w, pc_plus4_d_w, instr_d_w} !== {32'hFFFF_FFFC, 32'h0, 32'hFFFF_FE33}) begin
                    failures++;
                    $display("FAIL wrap_link got pcd=%h pc4=%h instr=%h exp pcd=fffffffc pc4=0 instr=fffffe33", pc_d_w, pc_plus4_d_w, instr_d_w);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_flush();
        test_redirect_stall();
        test_misalign();
        test_reset_mid_stall();
        test_back_to_back();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
